// File: rtl/pc_update_sequencer.sv
// pc_update_sequencer
//   Multicycle PC-update controller. It accepts a one-cycle update request
//   (or an exception request) from the main control unit and drives the
//   PC-source select together with the PC/EPC/MDR/memory strobes.
//   Plain updates take one cycle. An exception saves EPC, reads the handler
//   byte from the vector address into MDR, and then loads PC from MDR.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   req_valid     update request, sampled only while ready=1
//   req_kind[2:0] 0 SEQ, 1 BR, 2 JMP, 3 JR, 4 RTE, 5-7 illegal
//   br_cond       branch-taken flag, sampled with the request
//   exc_req       exception request, sampled only while ready=1 (beats req_valid)
//   exc_cause[1:0] exception cause; cause 3 shares the vector of cause 2
//   ready         high only in IDLE
//   pc_src_sel    000 ULA, 001 AluOut, 010 concat, 011 MDR, 100 EPC
//   pc_write, epc_write, mem_rd, mdr_write  load/read strobes
//   mem_addr_vec  steers the memory-address mux to vec_addr
//   vec_addr      latched exception vector address
//   done          one-cycle pulse when a request completes
module pc_update_sequencer #(
  parameter int unsigned MEM_WAIT = 2,
  parameter int unsigned VEC_BASE = 253
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_kind,
  input  logic        br_cond,
  input  logic        exc_req,
  input  logic [1:0]  exc_cause,
  output logic        ready,
  output logic [2:0]  pc_src_sel,
  output logic        pc_write,
  output logic        epc_write,
  output logic        mem_addr_vec,
  output logic [31:0] vec_addr,
  output logic        mem_rd,
  output logic        mdr_write,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    UPD      = 3'd1,
    EXC_SAVE = 3'd2,
    EXC_RD   = 3'd3,
    EXC_WAIT = 3'd4,
    EXC_MDR  = 3'd5,
    EXC_LOAD = 3'd6
  } state_t;

  localparam int unsigned CW = (MEM_WAIT > 2) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_INIT = (MEM_WAIT >= 2) ? CW'(MEM_WAIT - 2) : '0;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic [2:0]    pc_src_sel_q, pc_src_sel_d;
  logic          pc_write_q, pc_write_d;
  logic          epc_write_q, epc_write_d;
  logic          mem_addr_vec_q, mem_addr_vec_d;
  logic [31:0]   vec_addr_q, vec_addr_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mdr_write_q, mdr_write_d;
  logic          done_q, done_d;
  logic [1:0]    cause_eff;

  assign cause_eff = (exc_cause == 2'd3) ? 2'd2 : exc_cause;

  // Outputs are registered: each strobe is computed for the state being
  // entered, so it is visible during the whole cycle spent in that state.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_src_sel_d   = pc_src_sel_q;
    vec_addr_d     = vec_addr_q;
    pc_write_d     = 1'b0;
    epc_write_d    = 1'b0;
    mem_addr_vec_d = 1'b0;
    mem_rd_d       = 1'b0;
    mdr_write_d    = 1'b0;
    done_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (exc_req) begin
          state_d     = EXC_SAVE;
          epc_write_d = 1'b1;
          vec_addr_d  = 32'(VEC_BASE) + {30'd0, cause_eff};
        end else if (req_valid) begin
          state_d = UPD;
          done_d  = 1'b1;
          case (req_kind)
            3'd0: begin pc_src_sel_d = 3'b000; pc_write_d = 1'b1;    end
            3'd1: begin pc_src_sel_d = 3'b001; pc_write_d = br_cond; end
            3'd2: begin pc_src_sel_d = 3'b010; pc_write_d = 1'b1;    end
            3'd3: begin pc_src_sel_d = 3'b001; pc_write_d = 1'b1;    end
            3'd4: begin pc_src_sel_d = 3'b100; pc_write_d = 1'b1;    end
            default: ;
          endcase
        end
      end
      UPD: state_d = IDLE;
      EXC_SAVE: begin
        state_d        = EXC_RD;
        mem_addr_vec_d = 1'b1;
        mem_rd_d       = 1'b1;
      end
      EXC_RD: begin
        mem_addr_vec_d = 1'b1;
        if (MEM_WAIT <= 1) begin
          state_d     = EXC_MDR;
          mdr_write_d = 1'b1;
        end else begin
          state_d = EXC_WAIT;
          cnt_d   = WAIT_INIT;
        end
      end
      EXC_WAIT: begin
        mem_addr_vec_d = 1'b1;
        if (cnt_q == '0) begin
          state_d     = EXC_MDR;
          mdr_write_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      EXC_MDR: begin
        state_d      = EXC_LOAD;
        pc_src_sel_d = 3'b011;
        pc_write_d   = 1'b1;
        done_d       = 1'b1;
      end
      EXC_LOAD: state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      ready_q        <= 1'b1;
      pc_src_sel_q   <= '0;
      pc_write_q     <= 1'b0;
      epc_write_q    <= 1'b0;
      mem_addr_vec_q <= 1'b0;
      vec_addr_q     <= '0;
      mem_rd_q       <= 1'b0;
      mdr_write_q    <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ready_q        <= ready_d;
      pc_src_sel_q   <= pc_src_sel_d;
      pc_write_q     <= pc_write_d;
      epc_write_q    <= epc_write_d;
      mem_addr_vec_q <= mem_addr_vec_d;
      vec_addr_q     <= vec_addr_d;
      mem_rd_q       <= mem_rd_d;
      mdr_write_q    <= mdr_write_d;
      done_q         <= done_d;
    end
  end

  assign ready        = ready_q;
  assign pc_src_sel   = pc_src_sel_q;
  assign pc_write     = pc_write_q;
  assign epc_write    = epc_write_q;
  assign mem_addr_vec = mem_addr_vec_q;
  assign vec_addr     = vec_addr_q;
  assign mem_rd       = mem_rd_q;
  assign mdr_write    = mdr_write_q;
  assign done         = done_q;

endmodule
